// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared constants and types for the data_memory block.
//   DATA_W_DEFAULT : default data word width in bits
//   DEPTH_DEFAULT  : default number of stored words
//   word_t         : one data word of DATA_W_DEFAULT bits
// -----------------------------------------------------------------------------
package data_memory_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 256;

    typedef logic [DATA_W_DEFAULT-1:0] word_t;

endpackage

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-organised data memory with a combinational read port and a synchronous
// write port. Byte address bits [1:0] are ignored; bits [31:2] select the word.
// Word indices at or beyond DEPTH read as zero and writes to them are dropped.
// Asserting rst_n low clears every word asynchronously.
//
// Parameters
//   DATA_W    : data word width in bits
//   DEPTH     : number of words (power of two, >= 4)
//
// Ports
//   clk        in   1       clock, rising edge active
//   rst_n      in   1       asynchronous active-low reset
//   memWrite   in   1       write enable, sampled on rising clk
//   address    in   32      byte address
//   writeData  in   DATA_W  word to write
//   readData   out  DATA_W  word at the addressed location (combinational)
//   misaligned out  1       only with DATA_MEMORY_ALIGN_CHECK_EN: address[1:0] != 0
//
// Build option
//   DATA_MEMORY_ALIGN_CHECK_EN : adds the misaligned output and suppresses
//                                writes to non word-aligned addresses.
// -----------------------------------------------------------------------------
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memWrite,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    ,
    output logic              misaligned
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    // The full 30-bit word index is compared, so an out-of-range address can
    // never alias onto a low word through truncation.
    function automatic logic in_range(input logic [31:0] a);
        return a[31:2] < 30'(DEPTH);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              hit;
    logic              wr_en;

    assign idx = address[IDX_W+1:2];
    assign hit = in_range(address);

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    assign misaligned = (address[1:0] != 2'b00);
    assign wr_en      = memWrite && hit && !misaligned;
`else
    // Byte-select bits have no function in this build.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^address[1:0];
    assign wr_en           = memWrite && hit;
`endif

    // No write-to-read bypass: readData shows the stored word, so a write
    // becomes visible only after the edge that commits it.
    assign readData = hit ? mem_q[idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= writeData;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
// Scoreboard bench for data_memory. Each stimulus cycle pushes the expected
// readData (and misaligned, when built with DATA_MEMORY_ALIGN_CHECK_EN) into a
// queue; a monitor on the falling clock edge pops and compares.
// -----------------------------------------------------------------------------
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk;
    logic              rst_n;
    logic              memWrite;
    logic [31:0]       address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    logic              misaligned;
`endif

    data_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memWrite  (memWrite),
        .address   (address),
        .writeData (writeData),
        .readData  (readData)
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        ,
        .misaligned(misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: a plain array of words, address decode by division.
    word_t model [DEPTH];

    function automatic logic model_mis(input logic [31:0] a);
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic word_t model_read(input logic [31:0] a);
        int unsigned w;
        w = a / 4;
        if (w < DEPTH) return model[w];
        return '0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic expect_now(input string nm);
        exp_t e;
        e.nm   = nm;
        e.addr = address;
        e.data = model_read(address);
        e.mis  = model_mis(address);
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge. Drives one cycle of stimulus, records
    // the readData expected during this cycle, then applies the write to the
    // model after the edge that commits it.
    task automatic op(input logic we, input logic [31:0] a, input word_t wd, input string nm);
        int unsigned w;
        memWrite  = we;
        address   = a;
        writeData = wd;
        expect_now(nm);
        @(posedge clk);
        #1;
        w = a / 4;
        if (we && !model_mis(a) && w < DEPTH) model[w] = wd;
    endtask

    // Assert reset just after a rising edge with a write pending, hold it
    // across 'edges' rising edges, release between edges.
    task automatic pulse_reset(input int edges, input string nm);
        rst_n     = 1'b0;
        memWrite  = 1'b1;
        writeData = $urandom;
        model_clear();
        expect_now(nm);
        repeat (edges) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        memWrite = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (readData !== e.data) begin
                n_bad++;
                $display("FAIL %s: addr=%h readData=%h expected=%h", e.nm, e.addr, readData, e.data);
            end
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
            n_cmp++;
            if (misaligned !== e.mis) begin
                n_bad++;
                $display("FAIL %s_mis: addr=%h misaligned=%b expected=%b", e.nm, e.addr, misaligned, e.mis);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d expected completion", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        we;
        int unsigned sel;

        rst_n     = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        op(1'b0, 32'd0, '0, "rst_rd0");
        op(1'b0, 32'd4, '0, "rst_rd4");
        op(1'b0, 32'd8, '0, "rst_rd8");

        // Sequential writes and reads
        op(1'b1, 32'd0, 32'hAABBCCDD, "wr0");
        op(1'b0, 32'd0, 32'h0,        "rd0");
        op(1'b1, 32'd4, 32'h11223344, "wr4");
        op(1'b0, 32'd4, 32'h0,        "rd4");
        op(1'b1, 32'd8, 32'h55667788, "wr8");
        op(1'b0, 32'd8, 32'h0,        "rd8");
        op(1'b0, 32'd0, 32'h0,        "rd0_again");

        // Write disabled
        repeat (4) op(1'b0, 32'd4, 32'hDEADBEEF, "wdis");
        op(1'b0, 32'd4, 32'h0, "wdis_rd4");

        // Out of range, including one that would alias to word 0 if truncated
        op(1'b1, 32'(4*DEPTH), 32'hCAFEF00D, "oor_wr");
        op(1'b0, 32'(4*DEPTH), 32'h0,        "oor_rd");
        op(1'b0, 32'd0,        32'h0,        "oor_rd0");

        // Byte offset ignored on read
        op(1'b0, 32'd5, 32'h0, "lsb_rd5");

        // Read during write: old value this cycle, new value next
        op(1'b1, 32'd8, 32'h99AABBCC, "rdw_old");
        op(1'b0, 32'd8, 32'h0,        "rdw_new");

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        op(1'b1, 32'd2, 32'h12345678, "mis_wr2");
        op(1'b0, 32'd0, 32'h0,        "mis_rd0");
`endif

        // Async reset with no clock edge, then a reset held over edges with
        // a write pending
        address = 32'd8;
        pulse_reset(0, "arst_imm");
        op(1'b0, 32'd0, 32'h0, "arst_rd0");
        op(1'b0, 32'd4, 32'h0, "arst_rd4");
        address = 32'd12;
        pulse_reset(2, "arst_hold");
        op(1'b0, 32'd12, 32'h0, "arst_rd12");
        op(1'b1, 32'd12, 32'h0BADF00D, "resume_wr");
        op(1'b0, 32'd12, 32'h0, "resume_rd");

        // Randomized traffic concentrated on low words so aliasing shows up
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 32'($urandom_range(0, 63));
            else if (sel < 8)  a = 32'(4*DEPTH) + 32'($urandom_range(0, 63)) + 32'(4*DEPTH*$urandom_range(0, 3));
            else               a = $urandom;
            we = ($urandom_range(0, 2) == 0);
            op(we, a, $urandom, "rand");
            if (i == 200) begin
                pulse_reset(1, "rand_rst");
            end
        end

        memWrite = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
